// File: rtl/jump_ctrl.sv
// jump_ctrl: jump resolution stage.
// Decides taken/not-taken from the condition code and ALU flags, issues a
// one-cycle PC load with the forwarded target, and holds FLUSH for a fixed
// number of unstalled cycles. Also keeps the one-cycle writeback history
// (BUS_past, LD_reg_past) used by the upstream forwarding selector.
// Optional build macro JMP_STAT_EN adds taken / not-taken event counters.

module jump_ctrl #(
  parameter int unsigned DW           = 16,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [DW-1:0] BUS,
  input  logic [3:0]    LD_reg,
  output logic [DW-1:0] BUS_past,
  output logic [3:0]    LD_reg_past,
  input  logic          JMP_req,
  input  logic [2:0]    JMP_cond,
  input  logic [3:0]    FLAGS,
  input  logic [DW-1:0] Y2_sel,
  input  logic          STALL,
  output logic          PC_load,
  output logic [DW-1:0] PC_target,
  output logic          FLUSH,
  output logic          BUSY
`ifdef JMP_STAT_EN
  ,
  output logic [15:0]   JMP_taken_cnt,
  output logic [15:0]   JMP_nottaken_cnt
`endif
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_INIT = CW'(FLUSH_CYCLES - 1);

  typedef enum logic {
    IDLE,
    FLUSHING
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          cond_true;
  logic          eval;
  logic          unused_flag_v;

  // Overflow flag is not used by any condition code.
  assign unused_flag_v = FLAGS[0];

  // Condition decode from {Z,C,N,V}.
  always_comb begin
    cond_true = 1'b0;
    case (JMP_cond)
      3'd0:    cond_true = 1'b1;
      3'd1:    cond_true = FLAGS[3];
      3'd2:    cond_true = ~FLAGS[3];
      3'd3:    cond_true = FLAGS[2];
      3'd4:    cond_true = ~FLAGS[2];
      3'd5:    cond_true = FLAGS[1];
      3'd6:    cond_true = ~FLAGS[1];
      default: cond_true = 1'b0;
    endcase
  end

  // A request is evaluated only in IDLE while the pipeline is not held.
  assign eval = (state == IDLE) && JMP_req && !STALL;

  // Writeback history register, independent of stall and FSM state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      BUS_past    <= '0;
      LD_reg_past <= '0;
    end else begin
      BUS_past    <= BUS;
      LD_reg_past <= LD_reg;
    end
  end

  // Jump FSM with registered PC load, target and flush control.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      cnt       <= '0;
      PC_load   <= 1'b0;
      PC_target <= '0;
      FLUSH     <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          PC_load <= 1'b0;
          if (eval && cond_true) begin
            PC_load   <= 1'b1;
            PC_target <= Y2_sel;
            FLUSH     <= 1'b1;
            BUSY      <= 1'b1;
            cnt       <= CNT_INIT;
            state     <= FLUSHING;
          end
        end
        FLUSHING: begin
          PC_load <= 1'b0;
          if (!STALL) begin
            if (cnt == '0) begin
              FLUSH <= 1'b0;
              BUSY  <= 1'b0;
              state <= IDLE;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
        end
        default: begin
          PC_load <= 1'b0;
          FLUSH   <= 1'b0;
          BUSY    <= 1'b0;
          cnt     <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifdef JMP_STAT_EN
  // Event counters: taken counts PC load cycles, not-taken counts
  // evaluated requests whose condition failed. Both wrap at 16 bits.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      JMP_taken_cnt    <= '0;
      JMP_nottaken_cnt <= '0;
    end else begin
      if (PC_load) begin
        JMP_taken_cnt <= JMP_taken_cnt + 16'd1;
      end
      if (eval && !cond_true) begin
        JMP_nottaken_cnt <= JMP_nottaken_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
